// File: rtl/output_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_sram_arbiter_pkg
// Description : Shared constants and types for the output-SRAM write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package output_sram_arbiter_pkg;

    localparam int FV_size       = 16;
    localparam int MAX_FV_num    = 16;
    localparam int Max_Node_id   = 256;
    // Each SRAM row packs two feature-vector elements
    localparam int ROWS_PER_NODE = MAX_FV_num / 2;
    localparam int ADDR_W        = $clog2(Max_Node_id * ROWS_PER_NODE);

    // One output-SRAM row write
    typedef struct packed {
        logic                   wen;
        logic [ADDR_W-1:0]      addr;
        logic [2*FV_size-1:0]   wdata;
    } Out_SRAM_Wr;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/output_sram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational masked-priority round-robin pick. Requests at or
//               above the pointer win first; otherwise the lowest request wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import output_sram_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_masked;
    logic             w_hit_m;
    logic [PTR_W-1:0] w_idx_m;
    logic [PTR_W-1:0] w_idx_u;

    // Lowest set bit of the masked vector, falling back to the raw vector
    always_comb begin
        w_mask   = '0;
        w_hit_m  = 1'b0;
        w_idx_m  = '0;
        w_idx_u  = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (PTR_W'(i) >= ptr);
        end
        w_masked = req & w_mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_hit_m = 1'b1;
                w_idx_m = PTR_W'(i);
            end
            if (req[i]) begin
                w_idx_u = PTR_W'(i);
            end
        end
        any   = |req;
        idx   = w_hit_m ? w_idx_m : w_idx_u;
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/output_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_sram_arbiter
// Description : Shares the output-SRAM write port among vertex buffer banks.
//               Latches one-cycle bank requests, grants round-robin, and
//               forwards the granted bank's two-FV beats as SRAM row writes.
// Revision    : 1.0 - initial release
// ============================================================================
module output_sram_arbiter
    import output_sram_arbiter_pkg::*;
#(
    parameter int NUM_BANKS     = 4,
    parameter int FV_SIZE       = FV_size,
    parameter int MAX_FV_NUM    = MAX_FV_num,
    parameter int MAX_NODE_ID   = Max_Node_id,
    parameter int ROWS_PER_NODE = MAX_FV_NUM / 2,
    parameter int ADDR_W        = $clog2(MAX_NODE_ID * ROWS_PER_NODE)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_BANKS-1:0]                   bank_req,
    input  logic [NUM_BANKS-1:0]                   bank_grant_valid,
    input  logic [NUM_BANKS-1:0]                   bank_sos,
    input  logic [NUM_BANKS-1:0]                   bank_eos,
    input  logic [NUM_BANKS*$clog2(MAX_NODE_ID)-1:0] bank_nodeid,
    input  logic [NUM_BANKS*2*FV_SIZE-1:0]         bank_data,
    output logic [NUM_BANKS-1:0]                   req_grant,
    output logic                                   sram_wen,
    output logic [ADDR_W-1:0]                      sram_addr,
    output logic [2*FV_SIZE-1:0]                   sram_wdata,
    output logic                                   done,
    output logic [$clog2(MAX_NODE_ID)-1:0]         done_nodeid,
    output logic                                   busy,
    output logic                                   err
);

    localparam int NODE_W = $clog2(MAX_NODE_ID);
    localparam int PTR_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    // Beat counter must be able to hold ROWS_PER_NODE itself
    localparam int BEAT_W = $clog2(ROWS_PER_NODE + 1);
    localparam int DW     = 2 * FV_SIZE;

    arb_state_t             r_state;
    logic [NUM_BANKS-1:0]   r_pending;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_win;
    logic [NUM_BANKS-1:0]   r_win_oh;
    logic [ADDR_W-1:0]      r_base;
    logic [BEAT_W-1:0]      r_beat;
    logic [NODE_W-1:0]      r_nodeid;

    logic [NUM_BANKS-1:0]   r_req_grant;
    logic                   r_sram_wen;
    logic [ADDR_W-1:0]      r_sram_addr;
    logic [DW-1:0]          r_sram_wdata;
    logic                   r_done;
    logic [NODE_W-1:0]      r_done_nodeid;
    logic                   r_err;

    logic [NODE_W-1:0]      w_nodeid [NUM_BANKS];
    logic [DW-1:0]          w_data   [NUM_BANKS];

    logic [NUM_BANKS-1:0]   w_arb_grant;
    logic [PTR_W-1:0]       w_arb_idx;
    logic                   w_arb_any;

    logic                   w_sel_valid;
    logic                   w_sel_sos;
    logic                   w_sel_eos;
    logic [NODE_W-1:0]      w_sel_nodeid;
    logic [DW-1:0]          w_sel_data;
    logic                   w_active;
    logic [NUM_BANKS-1:0]   w_stray;
    logic [ADDR_W-1:0]      w_grant_base;
    logic [ADDR_W-1:0]      w_beat_addr;
    logic                   w_last_row;
    logic [PTR_W-1:0]       w_ptr_next;

    // Split the flattened per-bank buses into arrays
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_unpack
            assign w_nodeid[gi] = bank_nodeid[gi*NODE_W +: NODE_W];
            assign w_data[gi]   = bank_data[gi*DW +: DW];
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_BANKS),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (r_pending),
        .ptr   (r_rr_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx),
        .any   (w_arb_any)
    );

    assign w_sel_valid  = bank_grant_valid[r_win];
    assign w_sel_sos    = bank_sos[r_win];
    assign w_sel_eos    = bank_eos[r_win];
    assign w_sel_nodeid = w_nodeid[r_win];
    assign w_sel_data   = w_data[r_win];

    // Any valid outside the owning bank, or while no stream is open, is a protocol error
    assign w_active     = (r_state == ST_GRANT) || (r_state == ST_STREAM);
    assign w_stray      = bank_grant_valid & ~(w_active ? r_win_oh : '0);

    assign w_grant_base = ADDR_W'(w_sel_nodeid) * ADDR_W'(ROWS_PER_NODE);
    assign w_beat_addr  = r_base + ADDR_W'(r_beat);
    assign w_last_row   = (r_beat == BEAT_W'(ROWS_PER_NODE - 1));
    assign w_ptr_next   = (r_win == PTR_W'(NUM_BANKS - 1)) ? '0 : r_win + PTR_W'(1);

    // Request latch: a new pulse wins over the clear from a same-cycle grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~r_req_grant) | bank_req;
        end
    end

    // Arbitration / streaming FSM with registered grant, write and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_win         <= '0;
            r_win_oh      <= '0;
            r_base        <= '0;
            r_beat        <= '0;
            r_nodeid      <= '0;
            r_req_grant   <= '0;
            r_sram_wen    <= 1'b0;
            r_sram_addr   <= '0;
            r_sram_wdata  <= '0;
            r_done        <= 1'b0;
            r_done_nodeid <= '0;
            r_err         <= 1'b0;
        end else begin
            r_req_grant <= '0;
            r_sram_wen  <= 1'b0;
            r_done      <= 1'b0;
            if (|w_stray) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_win       <= w_arb_idx;
                        r_win_oh    <= w_arb_grant;
                        r_req_grant <= w_arb_grant;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_rr_ptr <= w_ptr_next;
                    if (w_sel_valid && w_sel_sos) begin
                        r_base       <= w_grant_base;
                        r_nodeid     <= w_sel_nodeid;
                        r_beat       <= BEAT_W'(1);
                        r_sram_wen   <= 1'b1;
                        r_sram_addr  <= w_grant_base;
                        r_sram_wdata <= w_sel_data;
                        if (w_sel_eos) begin
                            r_done        <= 1'b1;
                            r_done_nodeid <= w_sel_nodeid;
                            r_state       <= ST_IDLE;
                        end else if (ROWS_PER_NODE == 1) begin
                            r_err         <= 1'b1;
                            r_done        <= 1'b1;
                            r_done_nodeid <= w_sel_nodeid;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        // Bank did not open its stream; drop it without re-pending
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (w_sel_valid) begin
                        r_sram_wen   <= 1'b1;
                        r_sram_addr  <= w_beat_addr;
                        r_sram_wdata <= w_sel_data;
                        r_beat       <= r_beat + BEAT_W'(1);
                        if (w_sel_eos) begin
                            r_done        <= 1'b1;
                            r_done_nodeid <= r_nodeid;
                            r_state       <= ST_IDLE;
                        end else if (w_last_row) begin
                            // Node's row budget used up without eos: close it out
                            r_err         <= 1'b1;
                            r_done        <= 1'b1;
                            r_done_nodeid <= r_nodeid;
                            r_state       <= ST_IDLE;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_grant   = r_req_grant;
    assign sram_wen    = r_sram_wen;
    assign sram_addr   = r_sram_addr;
    assign sram_wdata  = r_sram_wdata;
    assign done        = r_done;
    assign done_nodeid = r_done_nodeid;
    assign busy        = (r_state != ST_IDLE) || (|r_pending);
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_output_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_sram_arbiter
// Description : Directed self-checking bench for output_sram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_sram_arbiter;

    localparam int NB = 4;
    localparam int NW = 8;
    localparam int AW = 11;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NB-1:0]     bank_req;
    logic [NB-1:0]     bank_grant_valid;
    logic [NB-1:0]     bank_sos;
    logic [NB-1:0]     bank_eos;
    logic [NB*NW-1:0]  bank_nodeid;
    logic [NB*DW-1:0]  bank_data;
    logic [NB-1:0]     req_grant;
    logic              sram_wen;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic              done;
    logic [NW-1:0]     done_nodeid;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+DW-1:0]  wr_q[$];
    logic [AW+DW-1:0]  exp_q[$];
    logic [NW-1:0]     done_q[$];
    int                grant_count = 0;

    output_sram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .bank_req         (bank_req),
        .bank_grant_valid (bank_grant_valid),
        .bank_sos         (bank_sos),
        .bank_eos         (bank_eos),
        .bank_nodeid      (bank_nodeid),
        .bank_data        (bank_data),
        .req_grant        (req_grant),
        .sram_wen         (sram_wen),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .done             (done),
        .done_nodeid      (done_nodeid),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Record SRAM writes, done pulses and grants mid-cycle
    always @(negedge clk) begin
        if (sram_wen) wr_q.push_back({sram_addr, sram_wdata});
        if (done) done_q.push_back(done_nodeid);
        if (|req_grant) grant_count++;
    end

    // Beat payload: upper FV = {node, 2k+1}, lower FV = {node, 2k}
    function automatic logic [DW-1:0] fv(input int n, input int k);
        return {8'(n), 8'(2*k+1), 8'(n), 8'(2*k)};
    endfunction

    function automatic bit q_match();
        if (wr_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [AW-1:0] first_addr();
        return (wr_q.size() > 0) ? wr_q[0][AW+DW-1:DW] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bank_req         = '0;
        bank_grant_valid = '0;
        bank_sos         = '0;
        bank_eos         = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        wr_q.delete();
        exp_q.delete();
        done_q.delete();
        grant_count = 0;
    endtask

    // Pulse a request in the current cycle and advance to the expected grant cycle
    task automatic pulse_and_wait(input logic [NB-1:0] mask);
        bank_req = mask;
        tick();
        bank_req = '0;
        tick();
    endtask

    task automatic send_stream(input int bank, input int nid, input int nbeats,
                               input bit with_eos, input int req_beat,
                               input logic [NB-1:0] req_mask);
        for (int k = 0; k < nbeats; k++) begin
            bank_grant_valid = '0;
            bank_sos         = '0;
            bank_eos         = '0;
            bank_grant_valid[bank] = 1'b1;
            bank_sos[bank]   = (k == 0);
            bank_eos[bank]   = with_eos && (k == nbeats - 1);
            bank_nodeid[bank*NW +: NW] = 8'(nid);
            bank_data[bank*DW +: DW]   = fv(nid, k);
            bank_req = (k == req_beat) ? req_mask : '0;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({req_grant, sram_wen, done, busy, err} !== '0)
            $display("FAIL reset_ctrl: got grant=%b wen=%b done=%b busy=%b err=%b, required all 0",
                     req_grant, sram_wen, done, busy, err);
        else n_pass++;
        n_checks++;
        if (sram_addr !== '0 || sram_wdata !== '0 || done_nodeid !== '0)
            $display("FAIL reset_data: got addr=%h wdata=%h nodeid=%h, required 0", sram_addr, sram_wdata, done_nodeid);
        else n_pass++;
        n_checks++;
        if (dut.r_pending !== 4'b0000)
            $display("FAIL reset_pending: got %b, required 0000", dut.r_pending);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        bank_req = 4'b0010;
        tick();
        bank_req = '0;
        n_checks++;
        if (busy !== 1'b1 || req_grant !== 4'b0000)
            $display("FAIL single_pending: got busy=%b grant=%b, required busy=1 grant=0000", busy, req_grant);
        else n_pass++;
        tick();
        n_checks++;
        if (req_grant !== 4'b0010)
            $display("FAIL single_grant: got %b, required 0010", req_grant);
        else n_pass++;
        send_stream(1, 5, 4, 1'b1, -1, '0);
        n_checks++;
        if (done !== 1'b1 || done_nodeid !== 8'd5 || sram_wen !== 1'b1 || sram_addr !== 11'd43)
            $display("FAIL single_done: got done=%b id=%0d wen=%b addr=%0d, required 1/5/1/43",
                     done, done_nodeid, sram_wen, sram_addr);
        else n_pass++;
        tick();
        for (int k = 0; k < 4; k++) exp_q.push_back({11'(40 + k), fv(5, k)});
        n_checks++;
        if (!q_match())
            $display("FAIL single_writes: got %0d writes first addr %0d, required 4 writes at 40..43",
                     wr_q.size(), first_addr());
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || done_q.size() != 1)
            $display("FAIL single_end: got done=%b busy=%b err=%b dones=%0d, required 0/0/0/1",
                     done, busy, err, done_q.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        pulse_and_wait(4'b0101);
        n_checks++;
        if (req_grant !== 4'b0001)
            $display("FAIL rr_first: got %b, required 0001", req_grant);
        else n_pass++;
        send_stream(0, 10, 2, 1'b1, -1, '0);
        n_checks++;
        if (req_grant !== 4'b0000)
            $display("FAIL rr_gap: got %b one cycle after eos, required 0000", req_grant);
        else n_pass++;
        tick();
        n_checks++;
        if (req_grant !== 4'b0100)
            $display("FAIL rr_second: got %b, required 0100", req_grant);
        else n_pass++;
        // Banks 0 and 3 request together while bank 2 streams
        send_stream(2, 20, 3, 1'b1, 0, 4'b1001);
        tick();
        n_checks++;
        if (req_grant !== 4'b1000)
            $display("FAIL rr_third: got %b, required 1000", req_grant);
        else n_pass++;
        send_stream(3, 30, 1, 1'b1, -1, '0);
        tick();
        n_checks++;
        if (req_grant !== 4'b0001)
            $display("FAIL rr_fourth: got %b, required 0001", req_grant);
        else n_pass++;
        send_stream(0, 40, 2, 1'b1, -1, '0);
        tick();
        exp_q.push_back({11'd80, fv(10, 0)});
        exp_q.push_back({11'd81, fv(10, 1)});
        for (int k = 0; k < 3; k++) exp_q.push_back({11'(160 + k), fv(20, k)});
        exp_q.push_back({11'd240, fv(30, 0)});
        exp_q.push_back({11'd320, fv(40, 0)});
        exp_q.push_back({11'd321, fv(40, 1)});
        n_checks++;
        if (!q_match() || err !== 1'b0)
            $display("FAIL rr_writes: got %0d writes err=%b, required 8 writes err=0", wr_q.size(), err);
        else n_pass++;
    endtask

    task automatic test_hold_during_stream();
        do_reset();
        pulse_and_wait(4'b0010);
        n_checks++;
        if (req_grant !== 4'b0010)
            $display("FAIL hold_grant1: got %b, required 0010", req_grant);
        else n_pass++;
        send_stream(1, 7, 4, 1'b1, 2, 4'b1000);
        n_checks++;
        if (dut.r_pending !== 4'b1000 || req_grant !== 4'b0000 || grant_count != 1)
            $display("FAIL hold_pending: got pending=%b grant=%b grants=%0d, required 1000/0000/1",
                     dut.r_pending, req_grant, grant_count);
        else n_pass++;
        tick();
        n_checks++;
        if (req_grant !== 4'b1000)
            $display("FAIL hold_grant3: got %b, required 1000", req_grant);
        else n_pass++;
        send_stream(3, 9, 2, 1'b1, -1, '0);
        tick();
        for (int k = 0; k < 4; k++) exp_q.push_back({11'(56 + k), fv(7, k)});
        exp_q.push_back({11'd72, fv(9, 0)});
        exp_q.push_back({11'd73, fv(9, 1)});
        n_checks++;
        if (!q_match() || err !== 1'b0)
            $display("FAIL hold_writes: got %0d writes err=%b, required 6 ordered writes err=0", wr_q.size(), err);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_and_wait(4'b0001);
        send_stream(0, 3, 9, 1'b0, -1, '0);
        tick();
        for (int k = 0; k < 8; k++) exp_q.push_back({11'(24 + k), fv(3, k)});
        n_checks++;
        if (!q_match())
            $display("FAIL ovf_writes: got %0d writes first addr %0d, required 8 writes at 24..31",
                     wr_q.size(), first_addr());
        else n_pass++;
        n_checks++;
        if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] !== 8'd3))
            $display("FAIL ovf_done: got %0d done pulses, required 1 with nodeid 3", done_q.size());
        else n_pass++;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL ovf_state: got err=%b busy=%b, required err=1 busy=0", err, busy);
        else n_pass++;
    endtask

    task automatic test_no_sos_and_stray();
        do_reset();
        pulse_and_wait(4'b0100);
        n_checks++;
        if (req_grant !== 4'b0100)
            $display("FAIL nosos_grant: got %b, required 0100", req_grant);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b1 || sram_wen !== 1'b0 || busy !== 1'b0)
            $display("FAIL nosos_state: got err=%b wen=%b busy=%b, required 1/0/0", err, sram_wen, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (wr_q.size() != 0 || grant_count != 1)
            $display("FAIL nosos_quiet: got writes=%0d grants=%0d, required 0/1", wr_q.size(), grant_count);
        else n_pass++;
        do_reset();
        n_checks++;
        if (err !== 1'b0)
            $display("FAIL stray_pre: got err=%b after reset, required 0", err);
        else n_pass++;
        bank_grant_valid = 4'b0010;
        bank_sos         = 4'b0010;
        tick();
        idle_inputs();
        n_checks++;
        if (err !== 1'b1 || sram_wen !== 1'b0)
            $display("FAIL stray_err: got err=%b wen=%b, required err=1 wen=0", err, sram_wen);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        pulse_and_wait(4'b0110);
        n_checks++;
        if (req_grant !== 4'b0010)
            $display("FAIL rst_grant: got %b, required 0010", req_grant);
        else n_pass++;
        send_stream(1, 6, 2, 1'b0, -1, '0);
        bank_grant_valid = 4'b0010;
        bank_nodeid[1*NW +: NW] = 8'd6;
        bank_data[1*DW +: DW]   = fv(6, 2);
        reset = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if ({req_grant, sram_wen, done, busy, err} !== '0 || sram_addr !== '0 ||
            sram_wdata !== '0 || done_nodeid !== '0 || dut.r_pending !== 4'b0000)
            $display("FAIL rst_outputs: got grant=%b wen=%b addr=%h done=%b busy=%b err=%b pend=%b, required all 0",
                     req_grant, sram_wen, sram_addr, done, busy, err, dut.r_pending);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        exp_q.push_back({11'd48, fv(6, 0)});
        exp_q.push_back({11'd49, fv(6, 1)});
        n_checks++;
        if (!q_match() || grant_count != 1 || done_q.size() != 0)
            $display("FAIL rst_after: got writes=%0d grants=%0d dones=%0d, required 2/1/0",
                     wr_q.size(), grant_count, done_q.size());
        else n_pass++;
    endtask

    initial begin
        reset            = 1'b1;
        bank_nodeid      = '0;
        bank_data        = '0;
        idle_inputs();
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        test_single();
        test_round_robin();
        test_hold_during_stream();
        test_overflow();
        test_no_sos_and_stray();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
